// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller sharing one 8-bit RAM/IO port between I-cache line fills
// and LSB loads/stores. Define MC_LOAD_ABORT_EN to let rob_clear cancel an in-flight load.
module mem_ctrl #(
    parameter int          LINE_BYTES = 64,
    parameter logic [31:0] IO_BASE    = 32'h30000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic                    io_buffer_full,
    input  logic                    if_en,
    input  logic [31:0]             if_pc,
    output logic [8*LINE_BYTES-1:0] if_data,
    output logic                    if_done,
    input  logic                    lsb_en,
    input  logic                    lsb_wr,
    input  logic [31:0]             lsb_addr,
    input  logic [1:0]              lsb_len,
    input  logic [31:0]             lsb_w_data,
    output logic [31:0]             lsb_r_data,
    output logic                    lsb_done,
    input  logic                    rob_clear
);
    localparam int         IDXW    = $clog2(8*LINE_BYTES);
    localparam logic [6:0] LAST_IF = 7'(LINE_BYTES-1);

    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t                  state_q, state_d;
    logic [6:0]              cnt_q, cnt_d, n_q, n_d;
    logic [31:0]             mem_a_q, mem_a_d, addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d, r_data_q, r_data_d;
    logic [7:0]              dout_q, dout_d;
    logic                    wr_q, wr_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
    logic [8*LINE_BYTES-1:0] if_data_q, if_data_d;
    logic [6:0]              len_n;
    logic                    load_kill;

`ifdef MC_LOAD_ABORT_EN
    assign load_kill = rob_clear;
`else
    logic unused_rob_clear;
    assign unused_rob_clear = rob_clear;
    assign load_kill        = 1'b0;
`endif

    always_comb begin
        case (lsb_len)
            2'd0:    len_n = 7'd1;
            2'd1:    len_n = 7'd2;
            default: len_n = 7'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        mem_a_d    = mem_a_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        r_data_d   = r_data_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        if_data_d  = if_data_q;
        if_done_d  = 1'b0;
        lsb_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A port whose done pulse is up this cycle is still dropping its en.
                if (lsb_en && !lsb_done_q && lsb_wr) begin
                    if (!(lsb_addr >= IO_BASE && io_buffer_full)) begin
                        addr_d  = lsb_addr;
                        wdata_d = lsb_w_data;
                        n_d     = len_n;
                        mem_a_d = lsb_addr;
                        dout_d  = lsb_w_data[7:0];
                        wr_d    = 1'b1;
                        cnt_d   = 7'd1;
                        state_d = LS_WRITE;
                    end
                end else if (lsb_en && !lsb_done_q && !load_kill) begin
                    n_d     = len_n;
                    mem_a_d = lsb_addr;
                    wr_d    = 1'b0;
                    cnt_d   = 7'd0;
                    state_d = LS_READ;
                end else if (if_en && !if_done_q) begin
                    mem_a_d = if_pc;
                    wr_d    = 1'b0;
                    cnt_d   = 7'd0;
                    state_d = IF_READ;
                end
            end
            IF_READ: begin
                if_data_d[IDXW'({cnt_q, 3'b000}) +: 8] = mem_din;
                if (cnt_q == LAST_IF) begin
                    if_done_d = 1'b1;
                    wr_d      = 1'b0;
                    mem_a_d   = 32'd0;
                    cnt_d     = 7'd0;
                    state_d   = IDLE;
                end else begin
                    cnt_d   = cnt_q + 7'd1;
                    mem_a_d = mem_a_q + 32'd1;
                end
            end
            LS_READ: begin
                if (load_kill) begin
                    wr_d    = 1'b0;
                    mem_a_d = 32'd0;
                    cnt_d   = 7'd0;
                    state_d = IDLE;
                end else begin
                    // First byte clears the upper bytes so short loads come back zero-extended.
                    if (cnt_q == 7'd0) r_data_d = {24'd0, mem_din};
                    else               r_data_d[{cnt_q[1:0], 3'b000} +: 8] = mem_din;
                    if (cnt_q == n_q - 7'd1) begin
                        lsb_done_d = 1'b1;
                        wr_d       = 1'b0;
                        mem_a_d    = 32'd0;
                        cnt_d      = 7'd0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 7'd1;
                        mem_a_d = mem_a_q + 32'd1;
                    end
                end
            end
            LS_WRITE: begin
                if (cnt_q == n_q) begin
                    wr_d       = 1'b0;
                    lsb_done_d = 1'b1;
                    cnt_d      = 7'd0;
                    state_d    = IDLE;
                end else if (addr_q >= IO_BASE && io_buffer_full) begin
                    wr_d = 1'b0;
                end else begin
                    mem_a_d = addr_q + {25'd0, cnt_q};
                    dout_d  = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    wr_d    = 1'b1;
                    cnt_d   = cnt_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            mem_a_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            r_data_q   <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
            if_data_q  <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            mem_a_q    <= mem_a_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            r_data_q   <= r_data_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            lsb_done_q <= lsb_done_d;
            if_data_q  <= if_data_d;
        end
    end

    // Masking with rdy keeps a frozen write cycle from committing the same byte repeatedly.
    assign mem_wr     = wr_q & rdy;
    assign mem_a      = mem_a_q;
    assign mem_dout   = dout_q;
    assign if_data    = if_data_q;
    assign if_done    = if_done_q;
    assign lsb_r_data = r_data_q;
    assign lsb_done   = lsb_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected done/write events, a negedge monitor pops and checks.
module tb_mem_ctrl;
    logic         clk = 1'b0;
    logic         rst, rdy, io_buffer_full, if_en, lsb_en, lsb_wr, rob_clear;
    logic [7:0]   mem_din, mem_dout;
    logic [31:0]  mem_a, if_pc, lsb_addr, lsb_w_data, lsb_r_data;
    logic         mem_wr, if_done, lsb_done;
    logic [1:0]   lsb_len;
    logic [511:0] if_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct { int cyc; logic [31:0] data; logic chk_data; } lsb_exp_t;
    typedef struct { int cyc; logic [511:0] data; } if_exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_exp_t;
    lsb_exp_t q_lsb[$];
    if_exp_t  q_if[$];
    wr_exp_t  q_wr[$];

    logic [7:0] ram [0:262143];
    logic       preload_done = 1'b0;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
        .if_en(if_en), .if_pc(if_pc), .if_data(if_data), .if_done(if_done),
        .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_w_data(lsb_w_data), .lsb_r_data(lsb_r_data), .lsb_done(lsb_done),
        .rob_clear(rob_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input int mode, input int k);
        return mode != 0 ? (8'(k) ^ 8'h5A) : 8'(k);
    endfunction

    function automatic logic [511:0] line_pat(input int mode);
        logic [511:0] v;
        v = '0;
        for (int k = 0; k < 64; k++) v[8*k +: 8] = pat(mode, k);
        return v;
    endfunction

    // RAM model: combinational read of mem_a, write on the edge that ends a mem_wr cycle.
    assign mem_din = ram[mem_a[17:0]];
    always @(posedge clk) begin
        if (!preload_done) begin
            for (int k = 0; k < 64; k++) begin
                ram[18'h40 + 18'(k)] <= pat(0, k);
                ram[18'h80 + 18'(k)] <= pat(1, k);
            end
            ram[18'h1000] <= 8'h11; ram[18'h1001] <= 8'h22;
            ram[18'h1002] <= 8'h33; ram[18'h1003] <= 8'h44;
            ram[18'h2000] <= 8'h00; ram[18'h2003] <= 8'h00;
            preload_done  <= 1'b1;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: event not expected at cycle %0d", name, cyc);
    endtask

    // Monitor: checks every done pulse and every committed write against the queues.
    always @(negedge clk) begin
        if (lsb_done) begin
            if (q_lsb.size() == 0) fail("unexpected lsb_done");
            else begin
                lsb_exp_t e;
                e = q_lsb.pop_front();
                chk32("lsb_done_cycle", 32'(cyc), 32'(e.cyc));
                if (e.chk_data) chk32("lsb_r_data", lsb_r_data, e.data);
            end
        end
        if (if_done) begin
            if (q_if.size() == 0) fail("unexpected if_done");
            else begin
                if_exp_t e;
                e = q_if.pop_front();
                chk32("if_done_cycle", 32'(cyc), 32'(e.cyc));
                chk_line("if_data", if_data, e.data);
            end
        end
        if (mem_wr) begin
            if (q_wr.size() == 0) fail("unexpected mem_wr");
            else begin
                wr_exp_t w;
                w = q_wr.pop_front();
                chk32("wr_addr", mem_a, w.addr);
                chk32("wr_data", 32'(mem_dout), 32'(w.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
        wr_exp_t w;
        w.addr = a;
        w.data = d;
        q_wr.push_back(w);
    endtask

    // Called just after an edge; lat counts cycles from the accepting edge (next edge if idle).
    task automatic lsb_req(input logic wr, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input int lat);
        lsb_exp_t e;
        bit seen;
        e.cyc = cyc + 1 + lat;
        e.data = exp_rd;
        e.chk_data = !wr;
        q_lsb.push_back(e);
        lsb_en = 1'b1; lsb_wr = wr; lsb_addr = addr; lsb_len = len; lsb_w_data = wd;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = lsb_done;
        end
        if (!seen) fail("lsb_done timeout");
        step();
        lsb_en = 1'b0;
    endtask

    task automatic if_req(input logic [31:0] pc, input logic [511:0] exp, input int lat);
        if_exp_t e;
        bit seen;
        e.cyc = cyc + 1 + lat;
        e.data = exp;
        q_if.push_back(e);
        if_en = 1'b1; if_pc = pc;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = if_done;
        end
        if (!seen) fail("if_done timeout");
        step();
        if_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rdy = 1'b1; io_buffer_full = 1'b0; if_en = 1'b0; if_pc = '0;
        lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_len = '0; lsb_w_data = '0;
        rob_clear = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk32("rst_mem_a", mem_a, 32'd0);
        chk32("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk32("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk32("rst_if_done", 32'(if_done), 32'd0);
        chk32("rst_lsb_done", 32'(lsb_done), 32'd0);
        chk32("rst_lsb_r_data", lsb_r_data, 32'd0);
        chk_line("rst_if_data", if_data, '0);
        step(); step();
        rst = 1'b1;
        step();

        // Reset asserted in the middle of a line fill clears everything at once.
        if_en = 1'b1; if_pc = 32'h40;
        repeat (10) step();
        #2 rst = 1'b0;
        #1;
        chk32("midfill_rst_mem_a", mem_a, 32'd0);
        chk_line("midfill_rst_if_data", if_data, '0);
        if_en = 1'b0;
        step(); step();
        rst = 1'b1;
        step();

        if_req(32'h40, line_pat(0), 64);

        // Simultaneous requests: load wins, IF follows in the load's done cycle.
        fork
            lsb_req(1'b0, 32'h1000, 2'd2, 32'd0, 32'h44332211, 4);
            if_req(32'h80, line_pat(1), 69);
        join
        step();
        chk32("no_if_reaccept_mem_a", mem_a, 32'd0);

        push_wr(32'h2001, 8'hEF);
        push_wr(32'h2002, 8'hBE);
        lsb_req(1'b1, 32'h2001, 2'd1, 32'h0000BEEF, 32'd0, 2);
        lsb_req(1'b0, 32'h2001, 2'd1, 32'd0, 32'h0000BEEF, 2);

        // IO store held off by a full buffer for five edges.
        io_buffer_full = 1'b1;
        push_wr(32'h30000, 8'h41);
        fork
            lsb_req(1'b1, 32'h30000, 2'd0, 32'h41, 32'd0, 6);
            begin repeat (5) step(); io_buffer_full = 1'b0; end
        join

        // rdy low three cycles in a load, two in a store.
        fork
            lsb_req(1'b0, 32'h2000, 2'd2, 32'd0, 32'h00BEEF00, 7);
            begin step(); step(); rdy = 1'b0; repeat (3) step(); rdy = 1'b1; end
        join
        push_wr(32'h3000, 8'hD4);
        push_wr(32'h3001, 8'hC3);
        push_wr(32'h3002, 8'hB2);
        push_wr(32'h3003, 8'hA1);
        fork
            lsb_req(1'b1, 32'h3000, 2'd2, 32'hA1B2C3D4, 32'd0, 6);
            begin step(); step(); rdy = 1'b0; step(); step(); rdy = 1'b1; end
        join
        lsb_req(1'b0, 32'h3000, 2'd2, 32'd0, 32'hA1B2C3D4, 4);

        // rob_clear one cycle into a word load.
        begin
`ifndef MC_LOAD_ABORT_EN
            lsb_exp_t e;
            e.cyc = cyc + 5;
            e.data = 32'h44332211;
            e.chk_data = 1'b1;
            q_lsb.push_back(e);
`endif
            lsb_en = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h1000; lsb_len = 2'd2;
            step();
            rob_clear = 1'b1; lsb_en = 1'b0;
            step();
            rob_clear = 1'b0;
            @(negedge clk);
`ifdef MC_LOAD_ABORT_EN
            chk32("rob_clear_mem_a", mem_a, 32'd0);
`else
            chk32("rob_clear_mem_a", mem_a, 32'h1001);
`endif
            repeat (8) step();
        end

        chk32("lsb_queue_left", 32'(q_lsb.size()), 32'd0);
        chk32("if_queue_left", 32'(q_if.size()), 32'd0);
        chk32("wr_queue_left", 32'(q_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
